// File: rtl/signed_divider_8bit.sv
// 16-by-8 signed divider: captures operand magnitudes, runs a 16-step unsigned
// restoring division MSB first, then applies truncating-division sign fix-up.
module signed_divider_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] Dividend,
    input  logic [7:0]  Divisor,
    output logic [7:0]  Quotient,
    output logic [7:0]  Remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // work_q starts as the dividend magnitude; quotient bits shift in from the LSB
    logic [15:0] work_q, work_d;
    logic [7:0]  dvs_mag_q, dvs_mag_d;
    logic [8:0]  rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dvd_neg_q, dvd_neg_d;
    logic        dvs_neg_q, dvs_neg_d;
    logic [7:0]  quo_q, quo_d;
    logic [7:0]  rmd_q, rmd_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;

    logic [15:0] dvd_mag_in;
    logic [7:0]  dvs_mag_in;
    logic [9:0]  trial;
    logic        trial_neg;
    logic        quo_neg;
    logic [7:0]  quo_signed;
    logic [7:0]  rmd_signed;
    logic        quo_ovf;

    // Magnitudes: the most negative values map onto their unsigned counterparts
    assign dvd_mag_in = Dividend[15] ? (16'd0 - Dividend) : Dividend;
    assign dvs_mag_in = Divisor[7]   ? (8'd0 - Divisor)   : Divisor;

    // One restoring step: partial remainder is at most 127, so the shifted
    // value fits in 9 bits and the 10-bit difference carries a valid sign
    assign trial     = {rem_q, work_q[15]} - {2'b00, dvs_mag_q};
    assign trial_neg = trial[9];

    assign quo_neg    = dvd_neg_q ^ dvs_neg_q;
    assign quo_signed = quo_neg   ? (8'd0 - work_q[7:0]) : work_q[7:0];
    assign rmd_signed = dvd_neg_q ? (8'd0 - rem_q[7:0])  : rem_q[7:0];
    assign quo_ovf    = quo_neg   ? (work_q > 16'd128)   : (work_q > 16'd127);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= 16'd0;
            dvs_mag_q <= 8'd0;
            rem_q     <= 9'd0;
            cnt_q     <= 4'd0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quo_q     <= 8'd0;
            rmd_q     <= 8'd0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            dvs_mag_q <= dvs_mag_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (Divisor == 8'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == 4'd15) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-values
    always_comb begin
        work_d    = work_q;
        dvs_mag_d = dvs_mag_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d    = dvd_mag_in;
                    dvs_mag_d = dvs_mag_in;
                    dvd_neg_d = Dividend[15];
                    dvs_neg_d = Divisor[7];
                    rem_d     = 9'd0;
                    cnt_d     = 4'd0;
                    if (Divisor == 8'd0) begin
                        quo_d = 8'h00;
                        rmd_d = 8'h00;
                        dbz_d = 1'b1;
                        ovf_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                rem_d  = trial_neg ? {rem_q[7:0], work_q[15]} : trial[8:0];
                work_d = {work_q[14:0], ~trial_neg};
                cnt_d  = cnt_q + 4'd1;
            end
            S_FIX: begin
                quo_d = quo_signed;
                rmd_d = rmd_signed;
                dbz_d = 1'b0;
                ovf_d = quo_ovf;
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign Quotient  = quo_q;
    assign Remainder = rmd_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_divider_8bit.sv
// Directed self-checking bench for signed_divider_8bit: hand-computed vectors,
// latency, start-while-busy handling and mid-operation reset.
module tb_signed_divider_8bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] Dividend;
    logic [7:0]  Divisor;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
    logic        busy;
    logic        done;
    logic        dbz;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    signed_divider_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue start, wait (bounded) for done, count edges after the start edge
    task automatic wait_done(output int lat);
        lat = -1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_div(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf, input int elat);
        int lat;
        @(negedge clk);
        Dividend = dvd;
        Divisor  = dvs;
        start    = 1'b1;
        wait_done(lat);
        check_eq({name, "_lat"}, lat, elat);
        if (lat >= 0) begin
            check_eq({name, "_q"},    Quotient, eq);
            check_eq({name, "_r"},    Remainder, er);
            check_eq({name, "_dbz"},  dbz, edbz);
            check_eq({name, "_ovf"},  ovf, eovf);
            check_eq({name, "_busy"}, busy, 1'b1);
            // start during the done cycle must be ignored
            Dividend = 16'h1234;
            Divisor  = 8'h00;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq({name, "_idle"}, {busy, done}, 2'b00);
            check_eq({name, "_hold"}, {Quotient, Remainder}, {eq, er});
        end
        $display("div %s: %h / %h -> q=%h r=%h dbz=%b ovf=%b lat=%0d",
                 name, dvd, dvs, Quotient, Remainder, dbz, ovf, lat);
    endtask

    initial begin
        int  lat;
        logic saw_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        Dividend = 16'h0000;
        Divisor  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {busy, done, dbz, ovf, Quotient, Remainder}, 20'h0);
        rst_n = 1'b1;

        do_div("pos_40_10",   16'h0028, 8'h0A, 8'h04, 8'h00, 1'b0, 1'b0, 17);
        do_div("neg_neg",     16'hFF92, 8'hF5, 8'h0A, 8'h00, 1'b0, 1'b0, 17);
        do_div("neg_pos",     16'hFFF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 17);
        do_div("pos_neg",     16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 17);
        do_div("max_pos_q",   16'h007F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 17);
        do_div("min_neg_q",   16'hFF00, 8'h02, 8'h80, 8'h00, 1'b0, 1'b0, 17);
        do_div("ovf_7fff",    16'h7FFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 17);
        do_div("ovf_m128_m1", 16'hFF80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 17);
        do_div("ovf_8000_80", 16'h8000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 17);
        do_div("ovf_1000_7",  16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b1, 17);
        do_div("dbz",         16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        do_div("after_dbz",   16'hFFF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 17);

        // start pulsed in CALC cycle 5 with other operands must be ignored
        @(negedge clk);
        Dividend = 16'h0028;
        Divisor  = 8'h0A;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        Dividend = 16'h7FFF;
        Divisor  = 8'h01;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 6; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        check_eq("busy_start_lat", lat, 17);
        check_eq("busy_start_res", {Quotient, Remainder, dbz, ovf}, {8'h04, 8'h00, 2'b00});
        $display("busy-start: q=%h r=%h ovf=%b lat=%0d", Quotient, Remainder, ovf, lat);

        // reset asserted in CALC cycle 8 aborts with no done pulse
        @(negedge clk);
        Dividend = 16'h03E8;
        Divisor  = 8'h07;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_calc", {busy, done, dbz, ovf, Quotient, Remainder}, 20'h0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check_eq("rst_no_done", saw_done, 1'b0);
        $display("mid-calc reset: busy=%b q=%h r=%h", busy, Quotient, Remainder);

        do_div("post_rst", 16'h0028, 8'h0A, 8'h04, 8'h00, 1'b0, 1'b0, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
